// File: rtl/rasterint_multi_ctrl.sv
// NCHAN raster-line comparators with a priority arbiter driving a timed, acknowledgeable INT pulse.
// Optional per-channel horizontal trigger position: define RASTERINT_HPOS_EN.
module rasterint_multi_ctrl #(
  parameter int unsigned NCHAN    = 4,
  parameter logic [7:0]  REGBASE  = 8'h40,
  parameter logic [8:0]  HTRIG    = 9'd0,
  parameter int unsigned INTWIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  input  logic [8:0] vcnt,
  input  logic [8:0] hcnt,
  input  logic       int_ack,
  output logic       int_n,
  output logic [2:0] int_src,
  output logic       vretraceint_disable
);

  typedef enum logic [1:0] {StIdle, StAssert, StGap} state_e;

  localparam int         NC   = int'(NCHAN);
  localparam logic [7:0] NREG = 8'(2 * NCHAN);

  logic [8:0]       line_q [NCHAN];
  logic [8:0]       line_d [NCHAN];
  logic [NCHAN-1:0] en_q, en_d;
  logic [NCHAN-1:0] pend_q, pend_d;
  logic [NCHAN-1:0] fire, clr, ack_clr;
  logic             vrd_q, vrd_d;
  state_e           state_q, state_d;
  logic             int_n_q, int_n_d;
  logic [2:0]       src_q, src_d, first;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      stat_wide;

  logic [7:0] offs;
  logic       sel_line, sel_ctrl, sel_stat;
  logic [2:0] ch;
`ifdef RASTERINT_HPOS_EN
  logic       sel_hpos;
  logic [8:0] hpos_q [NCHAN];
  logic [8:0] hpos_d [NCHAN];
`endif

  // Register decode relative to REGBASE; addresses below REGBASE wrap high and miss.
  assign offs = zxuno_addr - REGBASE;

  always_comb begin
    sel_line = 1'b0;
    sel_ctrl = 1'b0;
    sel_stat = 1'b0;
    ch       = '0;
`ifdef RASTERINT_HPOS_EN
    sel_hpos = 1'b0;
`endif
    if (offs < NREG) begin
      ch       = offs[3:1];
      sel_line = ~offs[0];
      sel_ctrl = offs[0];
    end else if (offs == NREG) begin
      sel_stat = 1'b1;
`ifdef RASTERINT_HPOS_EN
    end else if (offs <= NREG + 8'(NCHAN)) begin
      sel_hpos = 1'b1;
      ch       = 3'(offs - NREG - 8'd1);
`endif
    end
  end

  // STAT is MSB-aligned: flag, then pending[NCHAN-1:0], then zero pad.
  assign stat_wide = {vrd_q, pend_q, {(15 - NCHAN){1'b0}}};

  always_comb begin
    dout = 8'hFF;
    oe_n = 1'b1;
    if (zxuno_regrd) begin
      if (sel_stat) begin
        dout = stat_wide[15:8];
        oe_n = 1'b0;
      end
      for (int i = 0; i < NC; i++) begin
        if (ch == 3'(i)) begin
          if (sel_line) begin
            dout = line_q[i][7:0];
            oe_n = 1'b0;
          end
          if (sel_ctrl) begin
`ifdef RASTERINT_HPOS_EN
            dout = {pend_q[i], 4'b0000, hpos_q[i][8], en_q[i], line_q[i][8]};
`else
            dout = {pend_q[i], 5'b00000, en_q[i], line_q[i][8]};
`endif
            oe_n = 1'b0;
          end
`ifdef RASTERINT_HPOS_EN
          if (sel_hpos) begin
            dout = hpos_q[i][7:0];
            oe_n = 1'b0;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NC; i++) begin
`ifdef RASTERINT_HPOS_EN
      fire[i] = en_q[i] && (vcnt == line_q[i]) && (hcnt == hpos_q[i]);
`else
      fire[i] = en_q[i] && (vcnt == line_q[i]) && (hcnt == HTRIG);
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      line_d[i] = line_q[i];
`ifdef RASTERINT_HPOS_EN
      hpos_d[i] = hpos_q[i];
`endif
    end
    en_d  = en_q;
    vrd_d = vrd_q;
    clr   = '0;
    if (zxuno_regwr) begin
      for (int i = 0; i < NC; i++) begin
        if (ch == 3'(i)) begin
          if (sel_line) line_d[i][7:0] = din;
          if (sel_ctrl) begin
            line_d[i][8] = din[0];
            en_d[i]      = din[1];
`ifdef RASTERINT_HPOS_EN
            hpos_d[i][8] = din[2];
`endif
          end
`ifdef RASTERINT_HPOS_EN
          if (sel_hpos) hpos_d[i][7:0] = din;
`endif
        end
      end
      if (sel_stat) begin
        vrd_d = din[7];
        clr   = din[NCHAN-1:0];
      end
    end
    // A new match outranks any clear in the same cycle.
    pend_d = (pend_q & ~(clr | ack_clr)) | fire;
  end

  always_comb begin
    state_d = state_q;
    int_n_d = int_n_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    ack_clr = '0;
    first   = '0;
    for (int i = NC - 1; i >= 0; i--) begin
      if (pend_q[i]) first = 3'(i);
    end
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          src_d   = first;
          int_n_d = 1'b0;
          cnt_d   = 8'(INTWIDTH);
          state_d = StAssert;
        end
      end
      StAssert: begin
        if (int_ack) begin
          for (int i = 0; i < NC; i++) begin
            if (src_q == 3'(i)) ack_clr[i] = 1'b1;
          end
          int_n_d = 1'b1;
          state_d = StGap;
        end else if (cnt_q == 8'd1) begin
          // Timed out: pending stays set so the channel is retried.
          int_n_d = 1'b1;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: state_d = StIdle;
      default: begin
        state_d = StIdle;
        int_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        line_q[i] <= 9'h1FF;
`ifdef RASTERINT_HPOS_EN
        hpos_q[i] <= HTRIG;
`endif
      end
      en_q    <= '0;
      pend_q  <= '0;
      vrd_q   <= 1'b0;
      state_q <= StIdle;
      int_n_q <= 1'b1;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        line_q[i] <= line_d[i];
`ifdef RASTERINT_HPOS_EN
        hpos_q[i] <= hpos_d[i];
`endif
      end
      en_q    <= en_d;
      pend_q  <= pend_d;
      vrd_q   <= vrd_d;
      state_q <= state_d;
      int_n_q <= int_n_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign int_n               = int_n_q;
  assign int_src             = src_q;
  assign vretraceint_disable = vrd_q;

endmodule

// File: tb/tb_rasterint_multi_ctrl.sv
// Randomized and directed bench for rasterint_multi_ctrl against a register/pending reference model.
module tb_rasterint_multi_ctrl;

  localparam int         NCHAN    = 4;
  localparam logic [7:0] REGBASE  = 8'h40;
  localparam logic [8:0] HTRIG    = 9'd0;
  localparam int         INTWIDTH = 32;
`ifdef RASTERINT_HPOS_EN
  localparam int         NREGS    = 3 * NCHAN + 1;
`else
  localparam int         NREGS    = 2 * NCHAN + 1;
`endif
  localparam logic [7:0] STAT_A   = REGBASE + 8'(2 * NCHAN);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;
  logic [8:0] vcnt;
  logic [8:0] hcnt;
  logic       int_ack;
  logic       int_n;
  logic [2:0] int_src;
  logic       vretraceint_disable;

  rasterint_multi_ctrl #(
    .NCHAN   (NCHAN),
    .REGBASE (REGBASE),
    .HTRIG   (HTRIG),
    .INTWIDTH(INTWIDTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .zxuno_addr         (zxuno_addr),
    .zxuno_regrd        (zxuno_regrd),
    .zxuno_regwr        (zxuno_regwr),
    .din                (din),
    .dout               (dout),
    .oe_n               (oe_n),
    .vcnt               (vcnt),
    .hcnt               (hcnt),
    .int_ack            (int_ack),
    .int_n              (int_n),
    .int_src            (int_src),
    .vretraceint_disable(vretraceint_disable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the programmer-visible state.
  logic [8:0]       m_line [NCHAN];
  logic [8:0]       m_hpos [NCHAN];
  logic [NCHAN-1:0] m_en;
  logic [NCHAN-1:0] m_pend;
  logic             m_vrd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCHAN; i++) begin
      m_line[i] = 9'h1FF;
      m_hpos[i] = HTRIG;
    end
    m_en   = '0;
    m_pend = '0;
    m_vrd  = 1'b0;
  endtask

  function automatic logic [8:0] m_trig(input int i);
`ifdef RASTERINT_HPOS_EN
    return m_hpos[i];
`else
    return HTRIG;
`endif
  endfunction

  task automatic exp_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
    int off;
    int c;
    off = int'(a) - int'(REGBASE);
    c   = off / 2;
    d   = 8'hFF;
    oe  = 1'b1;
    if (off >= 0 && off < 2 * NCHAN) begin
      oe = 1'b0;
      if (off % 2 == 0) d = m_line[c][7:0];
`ifdef RASTERINT_HPOS_EN
      else d = {m_pend[c], 4'b0000, m_hpos[c][8], m_en[c], m_line[c][8]};
`else
      else d = {m_pend[c], 5'b00000, m_en[c], m_line[c][8]};
`endif
    end else if (off == 2 * NCHAN) begin
      oe = 1'b0;
      d  = {m_vrd, m_pend, 3'b000};
`ifdef RASTERINT_HPOS_EN
    end else if (off > 2 * NCHAN && off <= 3 * NCHAN) begin
      oe = 1'b0;
      d  = m_hpos[off - 2 * NCHAN - 1][7:0];
`endif
    end
  endtask

  // One clock: drive inputs, take the edge, then advance the model by the same rules.
  task automatic cycle(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [8:0] v, input logic [8:0] h, input logic ack, input int ack_ch);
    logic [NCHAN-1:0] hit;
    logic [NCHAN-1:0] clr;
    int off;
    zxuno_regwr = wr;
    zxuno_addr  = a;
    din         = d;
    vcnt        = v;
    hcnt        = h;
    int_ack     = ack;
    @(posedge clk);
    #1;
    zxuno_regwr = 1'b0;
    int_ack     = 1'b0;
    for (int i = 0; i < NCHAN; i++) hit[i] = m_en[i] && (v == m_line[i]) && (h == m_trig(i));
    clr = '0;
    if (wr) begin
      off = int'(a) - int'(REGBASE);
      if (off >= 0 && off < 2 * NCHAN) begin
        if (off % 2 == 0) m_line[off / 2][7:0] = d;
        else begin
          m_line[off / 2][8] = d[0];
          m_en[off / 2]      = d[1];
          m_hpos[off / 2][8] = d[2];
        end
      end else if (off == 2 * NCHAN) begin
        m_vrd = d[7];
        clr   = d[NCHAN-1:0];
`ifdef RASTERINT_HPOS_EN
      end else if (off > 2 * NCHAN && off <= 3 * NCHAN) begin
        m_hpos[off - 2 * NCHAN - 1][7:0] = d;
`endif
      end
    end
    if (ack) clr[ack_ch] = 1'b1;
    m_pend = (m_pend & ~clr) | hit;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 8'h00, 9'd0, 9'h1FF, 1'b0, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cycle(1'b1, a, d, 9'd0, 9'h1FF, 1'b0, 0);
  endtask

  task automatic rd(input logic [7:0] a, input string tag);
    logic [7:0] got_d;
    logic       got_oe;
    logic [7:0] exp_d;
    logic       exp_oe;
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    #1;
    got_d       = dout;
    got_oe      = oe_n;
    zxuno_regrd = 1'b0;
    exp_read(a, exp_d, exp_oe);
    check_eq({tag, "_dout"}, 32'(got_d), 32'(exp_d));
    check_eq({tag, "_oe_n"}, 32'(got_oe), 32'(exp_oe));
  endtask

  task automatic rd_const(input logic [7:0] a, input logic [7:0] exp_d, input logic exp_oe,
                          input string tag);
    logic [7:0] got_d;
    logic       got_oe;
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    #1;
    got_d       = dout;
    got_oe      = oe_n;
    zxuno_regrd = 1'b0;
    check_eq({tag, "_dout"}, 32'(got_d), 32'(exp_d));
    check_eq({tag, "_oe_n"}, 32'(got_oe), 32'(exp_oe));
  endtask

  task automatic wait_low(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (int_n == 1'b0) seen = 1'b1;
      else idle(1);
    end
    if (!seen) check_eq(tag, 32'(int_n), 32'd0);
  endtask

  int         n;
  int         m;
  int         c;
  logic       w;
  logic [7:0] a;
  logic [7:0] d;
  logic [8:0] v;
  logic [8:0] h;

  initial begin
    rst_n       = 1'b0;
    zxuno_addr  = 8'h00;
    zxuno_regrd = 1'b0;
    zxuno_regwr = 1'b0;
    din         = 8'h00;
    vcnt        = 9'd0;
    hcnt        = 9'h1FF;
    int_ack     = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    rd_const(REGBASE, 8'hFF, 1'b0, "rst_line0");
    rd_const(REGBASE + 8'd1, 8'h01, 1'b0, "rst_ctrl0");
    rd_const(STAT_A, 8'h00, 1'b0, "rst_stat");
    check_eq("rst_int_n", 32'(int_n), 32'd1);
    check_eq("rst_vrd", 32'(vretraceint_disable), 32'd0);
    check_eq("rst_int_src", 32'(int_src), 32'd0);

    // Single channel match, 1-cycle latency to pending and again to int_n, then ack.
    wr(REGBASE + 8'd2, 8'h20);
    wr(REGBASE + 8'd3, 8'h02);
    cycle(1'b0, 8'h00, 8'h00, 9'd32, HTRIG, 1'b0, 0);
    rd_const(STAT_A, 8'h10, 1'b0, "ch1_pend");
    check_eq("ch1_int_n_not_yet", 32'(int_n), 32'd1);
    idle(1);
    check_eq("ch1_int_n_low", 32'(int_n), 32'd0);
    check_eq("ch1_int_src", 32'(int_src), 32'd1);
    cycle(1'b0, 8'h00, 8'h00, 9'd0, 9'h1FF, 1'b1, 1);
    check_eq("ch1_ack_int_n", 32'(int_n), 32'd1);
    rd_const(REGBASE + 8'd3, 8'h02, 1'b0, "ch1_ctrl_after_ack");

    // Two simultaneous matches, timeout retry of the highest priority, then the other.
    wr(REGBASE + 8'd0, 8'd100);
    wr(REGBASE + 8'd1, 8'h02);
    wr(REGBASE + 8'd4, 8'd100);
    wr(REGBASE + 8'd5, 8'h02);
    cycle(1'b0, 8'h00, 8'h00, 9'd100, HTRIG, 1'b0, 0);
    wait_low("retry_first_low");
    check_eq("retry_src_first", 32'(int_src), 32'd0);
    n = 0;
    while (int_n == 1'b0 && n < 300) begin
      n++;
      idle(1);
    end
    check_eq("retry_low_len", 32'(n), 32'(INTWIDTH));
    m = 0;
    while (int_n == 1'b1 && m < 10) begin
      m++;
      idle(1);
    end
    check_eq("retry_gap_len_ok", 32'(m >= 1 && m <= 2), 32'd1);
    check_eq("retry_int_n_low_again", 32'(int_n), 32'd0);
    check_eq("retry_src_again", 32'(int_src), 32'd0);
    rd(STAT_A, "retry_stat");
    cycle(1'b0, 8'h00, 8'h00, 9'd0, 9'h1FF, 1'b1, 0);
    check_eq("ack0_int_n", 32'(int_n), 32'd1);
    wait_low("second_low");
    check_eq("second_src", 32'(int_src), 32'd2);
    cycle(1'b0, 8'h00, 8'h00, 9'd0, 9'h1FF, 1'b1, 2);
    check_eq("ack2_int_n", 32'(int_n), 32'd1);
    rd_const(STAT_A, 8'h00, 1'b0, "all_acked_stat");

    // vretrace disable flag, and set-beats-clear on pending.
    wr(STAT_A, 8'h80);
    check_eq("vrd_set", 32'(vretraceint_disable), 32'd1);
    wr(REGBASE + 8'd6, 8'h50);
    wr(REGBASE + 8'd7, 8'h02);
    cycle(1'b1, STAT_A, 8'h88, 9'h050, HTRIG, 1'b0, 0);
    rd_const(STAT_A, 8'hC0, 1'b0, "set_wins_stat");
    rd(REGBASE + 8'd7, "set_wins_ctrl3");

    // Asynchronous reset in the middle of a pulse.
    wait_low("ch3_low");
    check_eq("ch3_src", 32'(int_src), 32'd3);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_int_n", 32'(int_n), 32'd1);
    check_eq("async_rst_src", 32'(int_src), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    idle(1);
    rd_const(REGBASE, 8'hFF, 1'b0, "post_rst_line0");
    rd_const(REGBASE + 8'd7, 8'h01, 1'b0, "post_rst_ctrl3");
    rd_const(STAT_A, 8'h00, 1'b0, "post_rst_stat");
    check_eq("post_rst_vrd", 32'(vretraceint_disable), 32'd0);
    n = 0;
    for (int k = 0; k < 512; k++) begin
      cycle(1'b0, 8'h00, 8'h00, 9'(k), HTRIG, 1'b0, 0);
      if (int_n == 1'b0) n++;
    end
    check_eq("post_rst_no_int", 32'(n), 32'd0);

    // Horizontal trigger position.
`ifdef RASTERINT_HPOS_EN
    wr(REGBASE + 8'd0, 8'h10);
    wr(REGBASE + 8'd1, 8'h06);
    wr(STAT_A + 8'd1, 8'h00);
    rd_const(REGBASE + 8'd1, 8'h06, 1'b0, "hpos_ctrl0");
    rd_const(STAT_A + 8'd1, 8'h00, 1'b0, "hpos0_rd");
    cycle(1'b0, 8'h00, 8'h00, 9'h010, 9'h000, 1'b0, 0);
    rd_const(STAT_A, 8'h00, 1'b0, "hpos_no_match_at_0");
    cycle(1'b0, 8'h00, 8'h00, 9'h010, 9'h100, 1'b0, 0);
    rd_const(STAT_A, 8'h08, 1'b0, "hpos_match_at_256");
`else
    rd_const(STAT_A + 8'd1, 8'hFF, 1'b1, "hpos_undecoded");
    wr(REGBASE + 8'd1, 8'h07);
    rd_const(REGBASE + 8'd1, 8'h03, 1'b0, "ctrl_bit2_zero");
`endif

    // Randomized register traffic and raster positions against the model.
    for (int k = 0; k < 400; k++) begin
      c = int'($urandom_range(0, NCHAN - 1));
      w = ($urandom_range(0, 9) < 4);
      a = REGBASE + 8'($urandom_range(0, NREGS - 1));
      d = 8'($urandom);
      v = ($urandom_range(0, 3) != 0) ? m_line[c] : 9'($urandom);
      h = ($urandom_range(0, 3) != 0) ? m_trig(c) : 9'($urandom);
      cycle(w, a, d, v, h, 1'b0, 0);
      rd(REGBASE + 8'($urandom_range(0, NREGS)), "rand_rd");
      check_eq("rand_vrd", 32'(vretraceint_disable), 32'(m_vrd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
